// File: rtl/pipe_chain.sv
// Elastic pipeline-register chain with per-stage valid, stall and flush, and a
// valid/ready handshake at both ends. Optional backpressure counter: PIPE_CHAIN_PERF_CNT_EN.
module pipe_chain #(
  parameter int STAGES = 4,
  parameter int WIDTH  = 32,
  parameter int CNT_W  = $clog2(STAGES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [WIDTH-1:0]  in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [WIDTH-1:0]  out_data_o,
  input  logic              out_ready_i,
  input  logic [STAGES-1:0] stall_i,
  input  logic [STAGES-1:0] flush_i,
  output logic [STAGES-1:0] stage_valid_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [31:0]       stall_cnt_o
);

  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d     [STAGES];
  logic [STAGES-1:0] free;
  logic [STAGES-1:0] inc_v;
  logic [WIDTH-1:0]  inc_d [STAGES];

  // A stage is free when it is not stalled and is either empty or its item
  // moves on this cycle; walking from the output backwards lets bubbles collapse.
  always_comb begin
    logic pass_k;
    // NOTE: blocking assignments here, each output given a value before any read, so no latch is inferred.
    pass_k = out_ready_i;
    free   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      free[k] = ~stall_i[k] & (~v[k] | pass_k);
      pass_k  = free[k];
    end
  end

  // A flushed item is dropped on its way into the next stage, not just in place.
  always_comb begin
    inc_v[0] = in_valid_i;
    inc_d[0] = in_data_i;
    for (int k = 1; k < STAGES; k++) begin
      inc_v[k] = v[k-1] & ~flush_i[k-1];
      inc_d[k] = d[k-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      v <= '0;
      // NOTE: the payload registers are reset too so out_data_o is 0 out of reset.
      for (int k = 0; k < STAGES; k++) d[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (free[k]) begin
          v[k] <= inc_v[k];
          if (inc_v[k]) d[k] <= inc_d[k];
        end else begin
          v[k] <= v[k] & ~flush_i[k];
        end
      end
    end
  end

  // Occupancy comes from registered state only, so flush_i has no path to count_o.
  always_comb begin
    count_o = '0;
    for (int k = 0; k < STAGES; k++) count_o = count_o + CNT_W'(v[k]);
  end

  assign in_ready_o    = free[0];
  assign out_valid_o   = v[STAGES-1] & ~flush_i[STAGES-1];
  assign out_data_o    = d[STAGES-1];
  assign stage_valid_o = v;

`ifdef PIPE_CHAIN_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
    end else if (in_valid_i && !in_ready_o && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Scoreboard bench for pipe_chain (STAGES=4, WIDTH=32): the driver queues the
// payloads expected at the output, a negedge monitor pops and compares them.
module tb_pipe_chain;

  localparam int STAGES = 4;
  localparam int WIDTH  = 32;
  localparam int CNT_W  = 3;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              in_valid_i;
  logic [WIDTH-1:0]  in_data_i;
  logic              in_ready_o;
  logic              out_valid_o;
  logic [WIDTH-1:0]  out_data_o;
  logic              out_ready_i;
  logic [STAGES-1:0] stall_i;
  logic [STAGES-1:0] flush_i;
  logic [STAGES-1:0] stage_valid_o;
  logic [CNT_W-1:0]  count_o;
  logic [31:0]       stall_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] exp_q [$];

  pipe_chain #(.STAGES(STAGES), .WIDTH(WIDTH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_ready_o   (in_ready_o),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_ready_i  (out_ready_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .stage_valid_o(stage_valid_o),
    .count_o      (count_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid_i = 1'b0;
    for (int i = 0; i < n; i++) next();
  endtask

  // Offer one item for one cycle; the payload is queued only when the plan says it is accepted.
  task automatic push(input logic [WIDTH-1:0] data, input logic exp_ready, input string name);
    in_valid_i = 1'b1;
    in_data_i  = data;
    mid();
    check(name, in_ready_o, exp_ready);
    if (exp_ready) exp_q.push_back(data);
    next();
    in_valid_i = 1'b0;
  endtask

  // Output monitor: every output transfer must match the oldest expected payload.
  always @(negedge clk_i) begin
    if (rst_i && out_valid_o && out_ready_i && !stall_i[STAGES-1]) begin
      if (exp_q.size() == 0) check("out_while_empty", out_valid_o, 1'b0);
      else check("out_data", out_data_o, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int max_cnt;
    rst_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0;
    out_ready_i = 1'b1; stall_i = '0; flush_i = '0;

    // Reset state
    #3;
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_out_data", out_data_o, 32'h0);
    check("rst_stage_valid", stage_valid_o, 4'b0000);
    check("rst_count", count_o, 3'd0);
    check("rst_stall_cnt", stall_cnt_o, 32'd0);
    check("rst_in_ready", in_ready_o, 1'b1);
    stall_i = 4'b0001;
    #1;
    check("rst_in_ready_stall0", in_ready_o, 1'b0);
    stall_i = '0;
    next();
    rst_i = 1'b1;
    next();

    // Streaming and latency
    max_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid_i = (c < 3);
      in_data_i  = (c == 0) ? 32'h11 : (c == 1) ? 32'h22 : 32'h33;
      mid();
      if (c < 3) begin
        check("stream_in_ready", in_ready_o, 1'b1);
        exp_q.push_back(in_data_i);
      end
      check("stream_out_valid", out_valid_o, (c >= 4 && c <= 6));
      if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
      next();
    end
    in_valid_i = 1'b0;
    check("stream_count_peak", max_cnt, 3);

    // Bubble collapse behind a stalled output stage
    out_ready_i = 1'b0;
    push(32'hAA, 1'b1, "bub_push_aa");
    idle(3);
    mid();
    check("bub_only_s3", stage_valid_o, 4'b1000);
    next();
    stall_i = 4'b1000;
    push(32'h01, 1'b1, "bub_push_01");
    push(32'h02, 1'b1, "bub_push_02");
    push(32'h03, 1'b1, "bub_push_03");
    mid();
    check("bub_full", stage_valid_o, 4'b1111);
    next();
    push(32'h04, 1'b0, "bub_push_04_blocked");
    mid();
`ifdef PIPE_CHAIN_PERF_CNT_EN
    check("bub_stall_cnt", stall_cnt_o, 32'd1);
`else
    check("bub_stall_cnt", stall_cnt_o, 32'd0);
`endif
    next();
    stall_i = '0;
    out_ready_i = 1'b1;
    idle(6);
    check("bub_drained", stage_valid_o, 4'b0000);

    // Flush of an item that is moving
    push(32'h55, 1'b1, "fl_push_55");
    push(32'h66, 1'b1, "fl_push_66");
    exp_q.delete(exp_q.size() - 2);
    flush_i = 4'b0010;
    mid();
    check("fl_count_before", count_o, 3'd2);
    next();
    flush_i = '0;
    mid();
    check("fl_stage_valid", stage_valid_o, 4'b0010);
    check("fl_count_after", count_o, 3'd1);
    next();
    idle(5);

    // Flush beats stall on the same stage
    push(32'h77, 1'b1, "fs_push_77");
    push(32'h88, 1'b1, "fs_push_88");
    exp_q.delete(exp_q.size() - 2);
    next();
    mid();
    check("fs_setup", stage_valid_o, 4'b0110);
    stall_i = 4'b0100;
    flush_i = 4'b0100;
    next();
    stall_i = '0;
    flush_i = '0;
    mid();
    check("fs_stage_valid", stage_valid_o, 4'b0010);
    next();
    idle(5);

    // Output backpressure on a full pipe
    out_ready_i = 1'b0;
    push(32'hA1, 1'b1, "bp_push_a1");
    push(32'hA2, 1'b1, "bp_push_a2");
    push(32'hA3, 1'b1, "bp_push_a3");
    push(32'hA4, 1'b1, "bp_push_a4");
    for (int c = 0; c < 5; c++) begin
      in_valid_i = 1'b1;
      in_data_i  = 32'hB5;
      mid();
      check("bp_in_ready", in_ready_o, 1'b0);
      check("bp_out_data", out_data_o, 32'hA1);
      next();
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      mid();
      if (c == 0) begin
`ifdef PIPE_CHAIN_PERF_CNT_EN
        check("bp_stall_cnt", stall_cnt_o, 32'd6);
`else
        check("bp_stall_cnt", stall_cnt_o, 32'd0);
`endif
      end
      check("bp_drain_valid", out_valid_o, (c < 4));
      next();
    end

    // Asynchronous reset with a full pipe
    out_ready_i = 1'b0;
    push(32'hC1, 1'b1, "ar_push_c1");
    push(32'hC2, 1'b1, "ar_push_c2");
    push(32'hC3, 1'b1, "ar_push_c3");
    push(32'hC4, 1'b1, "ar_push_c4");
    check("ar_full", stage_valid_o, 4'b1111);
    #2;
    rst_i = 1'b0;
    #1;
    exp_q.delete();
    check("ar_stage_valid", stage_valid_o, 4'b0000);
    check("ar_out_valid", out_valid_o, 1'b0);
    check("ar_count", count_o, 3'd0);
    check("ar_stall_cnt", stall_cnt_o, 32'd0);
    next();
    rst_i = 1'b1;
    out_ready_i = 1'b1;
    in_valid_i = 1'b1;
    in_data_i  = 32'hD1;
    for (int c = 0; c < 6; c++) begin
      mid();
      if (c == 0) begin
        check("ar_push_d1", in_ready_o, 1'b1);
        exp_q.push_back(32'hD1);
      end
      check("ar_latency_valid", out_valid_o, (c == 4));
      next();
      in_valid_i = 1'b0;
    end

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_chain.md
Name: pipe_chain

Overview:
- Parametrised, elastic pipeline-register chain that replaces fixed lockstep stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB style).
- Depth and payload width are configurable.
- Each stage carries a valid bit, per-stage stall and flush, and a valid/ready handshake at both ends.
- Bubbles collapse: empty stages upstream of a stalled stage keep filling, so hazard stalls lose no throughput.

Parameters:
- STAGES, 4, number of register stages (>=1); stage 0 is the input side, stage STAGES-1 is the output side.
- WIDTH, 32, payload width in bits.
- CNT_W, $clog2(STAGES+1), width of the occupancy count.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  upstream offers in_data_i.
- in_data_i  in  WIDTH  payload entering stage 0.
- in_ready_o  out  1  stage 0 can accept this cycle (= free[0]).
- out_valid_o  out  1  stage STAGES-1 holds a live item.
- out_data_o  out  WIDTH  payload of stage STAGES-1.
- out_ready_i  in  1  downstream accepts the output item.
- stall_i  in  STAGES  bit k holds stage k.
- flush_i  in  STAGES  bit k discards the item currently in stage k.
- stage_valid_o  out  STAGES  valid bits of all stages.
- count_o  out  CNT_W  number of valid stages.
- stall_cnt_o  out  32  backpressure counter (see Optional Feature).

Behaviour:
- State: v[k] (1 bit) and d[k] (WIDTH bits) per stage.
- Reset (rst_i=0, asynchronous): all v[k]=0 and d[k]=0; therefore out_valid_o=0, out_data_o=0, stage_valid_o=0, count_o=0, stall_cnt_o=0. in_ready_o=1 during reset unless stall_i[0]=1.
- Combinational pass/free chain, evaluated from the output stage backwards:
  - pass[STAGES-1] = out_ready_i.
  - pass[k] = free[k+1] for k < STAGES-1.
  - free[k] = ~stall_i[k] & (~v[k] | pass[k]).
- Incoming valid per stage:
  - inc_v[0] = in_valid_i.
  - inc_v[k] = v[k-1] & ~flush_i[k-1].
  - inc_d[0] = in_data_i; inc_d[k] = d[k-1].
- Next state:
  - If free[k]: v[k] <= inc_v[k]; d[k] <= inc_d[k] only when inc_v[k]=1 (data holds otherwise).
  - Else: v[k] <= v[k] & ~flush_i[k]; d[k] holds.
- Output:
  - out_valid_o = v[STAGES-1] & ~flush_i[STAGES-1].
  - out_data_o = d[STAGES-1].
  - A transfer occurs when out_valid_o & out_ready_i & ~stall_i[STAGES-1].
- Input: a transfer occurs when in_valid_i & in_ready_o.
- Priority:
  - Flush beats stall.
  - A flushed item never appears in any downstream stage, including when it would have moved that cycle.
  - Flush and stall of the same stage together: the stage is emptied and stays blocked for incoming data that cycle.
- Stall propagation:
  - Stall on stage k blocks stage k.
  - Upstream stages are blocked only if they are valid.
  - An empty stage j<k still loads.
- Latency: STAGES cycles from input transfer to out_valid_o, with an empty pipe and no stalls.
- Throughput: 1 item/cycle.
- count_o = popcount(v), registered state only, so no combinational path from flush_i.
- Ordering: items never reorder or duplicate; the chain holds at most STAGES items.
- Reset mid-operation: all in-flight items are lost immediately; no output glitch beyond the asynchronous clear.
- STAGES=1: a single elastic register with full-throughput pass-through (free[0]=~stall_i[0]&(~v[0]|out_ready_i)).

Optional Feature:
- Macro: PIPE_CHAIN_PERF_CNT_EN.
- Defined:
  - stall_cnt_o increments on every cycle where in_valid_i=1 and in_ready_o=0.
  - Saturates at 32'hFFFF_FFFF; cleared only by reset.
- Undefined:
  - Counter logic is absent; stall_cnt_o is tied to 32'd0.
  - All other behaviour is identical.

Test Plan (STAGES=4, WIDTH=32):
- Streaming: feed 0x11,0x22,0x33 on consecutive cycles with out_ready_i=1 and no stalls -> out_valid_o rises 4 cycles after 0x11; outputs 0x11,0x22,0x33 on 3 consecutive cycles; count_o peaks at 3.
- Bubble collapse: pipe holds only stage 3 (0xAA); stall_i=4'b1000; push 0x01,0x02,0x03 -> all accepted (in_ready_o=1 for 3 cycles); stage_valid_o=4'b1111; the 4th push sees in_ready_o=0; with the perf macro on, stall_cnt_o=1 after that cycle.
- Flush while moving: 0x55 in stage 1 with no stall; assert flush_i=4'b0010 for one cycle -> 0x55 never reaches stage 2 or the output; count_o drops by 1.
- Flush beats stall: stage 2 valid, stall_i[2]=1 and flush_i[2]=1 for one cycle -> stage_valid_o[2]=0 next cycle; stage 1 contents stay in stage 1.
- Output backpressure: full pipe, out_ready_i=0 for 5 cycles -> out_data_o stable; in_ready_o=0; perf counter (macro on) counts 5 with in_valid_i=1; releasing out_ready_i drains 4 items in order over 4 cycles.
- Async reset: full pipe; pull rst_i low mid-cycle -> stage_valid_o=0, out_valid_o=0, count_o=0 before the next clock edge; after release, first push emerges after 4 cycles.
